adder_result_tagger: RTL and testbench
======================================

# adder_result_tagger

Synthesizable result checker that sits beside an adder DUT in hardware-in-the-loop and emulation builds. It recomputes the reference sum for every operand set and classifies each result into the team's four report colours (WHITE/BLUE/YELLOW/RED). It keeps saturating per-colour counters and buffers every event at or above a configurable severity in a FIFO. The FIFO is drained over a valid/ready port by a logger or debug bridge.

## Interface
- WIDTH, 8: adder operand and sum width.
- DEPTH, 16: FIFO entries; a power of two, at least 2.
- CNT_WIDTH, 16: width of the event and drop counters.
- MIN_COLOUR, 2 (YELLOW): an event is enqueued only if its colour is at or above this value.
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear of all counters and the overflow flag.
- in_valid  in  1  operand/result set present; always accepted, no ready.
- in_a, in_b  in  WIDTH  operands driven to the DUT.
- in_cin  in  1  carry-in driven to the DUT.
- dut_sum  in  WIDTH  DUT sum output.
- dut_cout  in  1  DUT carry-out.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the FIFO head.
- out_colour  out  2  colour of the FIFO head.
- out_a, out_b, out_sum  out  WIDTH  stored operands and DUT sum.
- out_cin, out_cout  out  1  stored carry-in and DUT carry-out.
- level  out  $clog2(DEPTH+1)  current FIFO occupancy.
- cnt_white, cnt_blue, cnt_yellow, cnt_red  out  CNT_WIDTH  per-colour event counts.
- drop_cnt  out  CNT_WIDTH  events lost because the FIFO was full.
- overflow  out  1  sticky flag: at least one event was dropped.

## Operation
- Reference result: {exp_cout, exp_sum} = in_a + in_b + in_cin, computed at WIDTH+1 bits.
- Colour is assigned by the first matching rule, in this priority order:
  - RED (3): {dut_cout, dut_sum} differs from the reference result.
  - YELLOW (2): the result matches and dut_cout = 1.
  - BLUE (1): the result matches and dut_sum = 0.
  - WHITE (0): all other cases.
- Stage 1 registers the colour and the payload when in_valid = 1.
- Stage 2 acts on the registered event:
  - Increments the matching counter; counters saturate at all-ones.
  - Pushes the event if colour >= MIN_COLOUR.
- Pushing when full with no same-cycle pop:
  - The event is discarded.
  - drop_cnt increments (saturating).
  - overflow is set.
- clear in the same cycle as an increment: clear wins, and the counter reads 0.
- clear does not flush the FIFO.
- Output handshake:
  - An entry pops on out_valid && out_ready.
  - While out_valid = 1, the out_* signals are stable until the pop.
- Reset value of every output is 0: out_valid, out_*, level, all counters, drop_cnt, overflow.
- Reset asserted mid-operation:
  - Empties the FIFO and the stage-1 register immediately.
  - Any in-flight event is lost and is not counted.

## Timing
- Event accepted in cycle N: colour is registered at the end of N.
- Counter update and FIFO write happen at the end of N+1.
- Counters are visible in N+2; out_valid rises in N+2 when the FIFO was empty. There is no bypass.
- Throughput: one event per cycle on input and output.
- Full FIFO with push and pop in the same cycle: both succeed, level is unchanged, no drop.
- Empty FIFO: out_valid stays 0; out_ready is ignored.
- Pointers wrap modulo DEPTH. level equals DEPTH exactly when full.

## Configuration
- ADDER_TAGGER_SIGNED_OVF_EN
  - Defined: YELLOW also fires on signed overflow of a matching result, i.e. in_a[MSB] == in_b[MSB] and dut_sum[MSB] differs.
  - Undefined: YELLOW fires on carry-out only.
  - The priority order is the same in both builds.

## Structure
- adder_colours_pkg holds:
  - colour_t: WHITE=0, BLUE=1, YELLOW=2, RED=3, 2-bit encoding.
  - Colour-to-counter index constants.
- One sub-module, adder_tag_fifo:
  - Synchronous FIFO parametrised on payload width and DEPTH.
  - Exposes push, pop, full, empty, level and the head data.
- Classification, counters and drop logic live in the top module.

## Test plan
All scenarios use WIDTH=8, DEPTH=16, MIN_COLOUR=2 unless stated.
- a=05, b=0A, cin=0, sum=0F, cout=0 → WHITE; cnt_white=1 in N+2; out_valid stays 0.
- a=FF, b=01, cin=0, sum=00, cout=1 → YELLOW (beats BLUE); out_valid in N+2; out_colour=2, out_sum=00.
- a=10, b=20, cin=1, sum=30, cout=0 → RED; cnt_red=1; entry carries sum=30, cin=1.
- Hold out_ready=0 and send 17 RED events:
  - Expect level=16, drop_cnt=1, overflow=1.
  - Then pulse clear: all counters 0, overflow=0, level still 16.
- While full, assert out_ready and send one RED event in the same cycle:
  - Expect level stays 16, drop_cnt unchanged, old head popped.
- Macro checks with a=7F, b=01, sum=80, cout=0:
  - Built with ADDER_TAGGER_SIGNED_OVF_EN: YELLOW.
  - Built without: WHITE.
- Assert rst_n at level=5: out_valid, level and all counters are 0 before the next edge.

Source files
------------

// File: rtl/adder_colours_pkg.sv
// Shared colour encoding and counter indices for the adder result tagger.
package adder_colours_pkg;

  typedef enum logic [1:0] {
    WHITE  = 2'd0,
    BLUE   = 2'd1,
    YELLOW = 2'd2,
    RED    = 2'd3
  } colour_t;

  localparam int NUM_COLOURS    = 4;
  localparam int CNT_IDX_WHITE  = 0;
  localparam int CNT_IDX_BLUE   = 1;
  localparam int CNT_IDX_YELLOW = 2;
  localparam int CNT_IDX_RED    = 3;

endpackage

// File: rtl/adder_result_tagger_if.sv
// Operand/result input bundle and FIFO drain port of the adder result tagger.
interface adder_result_tagger_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic [WIDTH-1:0] dut_sum;
  logic             dut_cout;

  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_colour;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [WIDTH-1:0] out_sum;
  logic             out_cin;
  logic             out_cout;

  modport master (
    output in_valid, in_a, in_b, in_cin, dut_sum, dut_cout, out_ready,
    input  out_valid, out_colour, out_a, out_b, out_sum, out_cin, out_cout
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, dut_sum, dut_cout, out_ready,
    output out_valid, out_colour, out_a, out_b, out_sum, out_cin, out_cout
  );
endinterface

// File: rtl/adder_tag_fifo.sv
// Synchronous FIFO for tagged events; head data reads 0 while empty.
module adder_tag_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign level_o = level_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      level_d = level_q + LW'(1);
    else if (!do_push && do_pop) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/adder_result_tagger.sv
// Adder result checker: classifies each result by colour, counts, and queues severe events.
// Build option ADDER_TAGGER_SIGNED_OVF_EN: signed overflow of a matching result also reports YELLOW.
module adder_result_tagger
  import adder_colours_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int MIN_COLOUR = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  adder_result_tagger_if.slave       bus,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [CNT_WIDTH-1:0]       cnt_white,
  output logic [CNT_WIDTH-1:0]       cnt_blue,
  output logic [CNT_WIDTH-1:0]       cnt_yellow,
  output logic [CNT_WIDTH-1:0]       cnt_red,
  output logic [CNT_WIDTH-1:0]       drop_cnt,
  output logic                       overflow
);
  typedef struct packed {
    colour_t          colour;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             cin;
    logic             cout;
  } evt_t;

  localparam int         EVT_W = $bits(evt_t);
  localparam logic [1:0] MIN_C = 2'(MIN_COLOUR);

  logic [WIDTH:0] exp_res;
  logic           mismatch, yel;
  evt_t           evt_d, evt_q;
  logic           s1_vld_q;

  always_comb begin
    exp_res  = {1'b0, bus.in_a} + {1'b0, bus.in_b} + {{WIDTH{1'b0}}, bus.in_cin};
    mismatch = ({bus.dut_cout, bus.dut_sum} != exp_res);
`ifdef ADDER_TAGGER_SIGNED_OVF_EN
    yel = bus.dut_cout ||
          ((bus.in_a[WIDTH-1] == bus.in_b[WIDTH-1]) && (bus.dut_sum[WIDTH-1] != bus.in_a[WIDTH-1]));
`else
    yel = bus.dut_cout;
`endif
    evt_d.a    = bus.in_a;
    evt_d.b    = bus.in_b;
    evt_d.sum  = bus.dut_sum;
    evt_d.cin  = bus.in_cin;
    evt_d.cout = bus.dut_cout;
    if (mismatch)               evt_d.colour = RED;
    else if (yel)               evt_d.colour = YELLOW;
    else if (bus.dut_sum == '0) evt_d.colour = BLUE;
    else                        evt_d.colour = WHITE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      evt_q    <= '0;
    end else begin
      s1_vld_q <= bus.in_valid;
      if (bus.in_valid) evt_q <= evt_d;
    end
  end

  // Stage 2: count, then queue or drop.
  logic             push_req, pop, full, empty, drop_ev;
  logic [EVT_W-1:0] head_bits;
  evt_t             head;

  assign push_req = s1_vld_q && (evt_q.colour >= MIN_C);
  assign pop      = !empty && bus.out_ready;
  assign drop_ev  = push_req && full && !pop;

  logic [NUM_COLOURS-1:0][CNT_WIDTH-1:0] cnt_all;

  for (genvar c = 0; c < NUM_COLOURS; c++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    always_comb begin
      cnt_d = cnt_q;
      if (clear) cnt_d = '0;
      else if (s1_vld_q && (evt_q.colour == 2'(c)) && (cnt_q != '1))
        cnt_d = cnt_q + CNT_WIDTH'(1);
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end
    assign cnt_all[c] = cnt_q;
  end

  assign cnt_white  = cnt_all[CNT_IDX_WHITE];
  assign cnt_blue   = cnt_all[CNT_IDX_BLUE];
  assign cnt_yellow = cnt_all[CNT_IDX_YELLOW];
  assign cnt_red    = cnt_all[CNT_IDX_RED];

  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic                 ovf_q, ovf_d;

  always_comb begin
    drop_d = drop_q;
    ovf_d  = ovf_q;
    if (clear) begin
      drop_d = '0;
      ovf_d  = 1'b0;
    end else if (drop_ev) begin
      if (drop_q != '1) drop_d = drop_q + CNT_WIDTH'(1);
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      drop_q <= drop_d;
      ovf_q  <= ovf_d;
    end
  end

  assign drop_cnt = drop_q;
  assign overflow = ovf_q;

  adder_tag_fifo #(.W(EVT_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_req),
    .data_i  (evt_q),
    .pop_i   (pop),
    .data_o  (head_bits),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign head           = evt_t'(head_bits);
  assign bus.out_valid  = !empty;
  assign bus.out_colour = head.colour;
  assign bus.out_a      = head.a;
  assign bus.out_b      = head.b;
  assign bus.out_sum    = head.sum;
  assign bus.out_cin    = head.cin;
  assign bus.out_cout   = head.cout;
endmodule

// File: tb/tb_adder_result_tagger.sv
// Directed bench for adder_result_tagger: colour table, overflow/clear, full push+pop, mid-run reset.
module tb_adder_result_tagger;
  import adder_colours_pkg::*;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic [4:0]    level;
  logic [CW-1:0] cnt_white, cnt_blue, cnt_yellow, cnt_red, drop_cnt;
  logic          overflow;

  adder_result_tagger_if #(.WIDTH(W)) bus ();

  adder_result_tagger #(.WIDTH(W), .DEPTH(D), .CNT_WIDTH(CW), .MIN_COLOUR(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .bus        (bus),
    .level      (level),
    .cnt_white  (cnt_white),
    .cnt_blue   (cnt_blue),
    .cnt_yellow (cnt_yellow),
    .cnt_red    (cnt_red),
    .drop_cnt   (drop_cnt),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ev(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic [7:0] sum, input logic cout);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.dut_sum  = sum;
    bus.dut_cout = cout;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  function automatic logic [CW-1:0] cnt_of(input int c);
    case (c)
      0:       return cnt_white;
      1:       return cnt_blue;
      2:       return cnt_yellow;
      default: return cnt_red;
    endcase
  endfunction

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic [1:0] colour;
  } vec_t;

  vec_t vecs [8];

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.dut_sum   = '0;
    bus.dut_cout  = 1'b0;
    bus.out_ready = 1'b0;

    vecs[0] = '{8'h05, 8'h0A, 1'b0, 8'h0F, 1'b0, 2'd0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 2'd2};
    vecs[2] = '{8'h10, 8'h20, 1'b1, 8'h30, 1'b0, 2'd3};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 2'd1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b0, 2'd3};
    vecs[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 2'd0};
`ifdef ADDER_TAGGER_SIGNED_OVF_EN
    vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 2'd2};
`else
    vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 2'd0};
`endif
    vecs[7] = '{8'hC0, 8'h40, 1'b0, 8'h00, 1'b1, 2'd2};

    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_cnt_white", cnt_white, 0);
    chk("rst_cnt_red", cnt_red, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_out_a", bus.out_a, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      logic push;
      push = (vecs[i].colour >= 2'd2);
      pulse_clear();
      drive_ev(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout);
      tick();
      bus.in_valid = 1'b0;
      chk($sformatf("v%0d_nobypass", i), bus.out_valid, 0);
      tick();
      for (int c = 0; c < 4; c++)
        chk($sformatf("v%0d_cnt%0d", i, c), cnt_of(c), (c == int'(vecs[i].colour)) ? 1 : 0);
      chk($sformatf("v%0d_out_valid", i), bus.out_valid, push);
      if (push) begin
        chk($sformatf("v%0d_colour", i), bus.out_colour, vecs[i].colour);
        chk($sformatf("v%0d_a", i), bus.out_a, vecs[i].a);
        chk($sformatf("v%0d_b", i), bus.out_b, vecs[i].b);
        chk($sformatf("v%0d_sum", i), bus.out_sum, vecs[i].sum);
        chk($sformatf("v%0d_cin", i), bus.out_cin, vecs[i].cin);
        chk($sformatf("v%0d_cout", i), bus.out_cout, vecs[i].cout);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
      end
      chk($sformatf("v%0d_level", i), level, 0);
    end

    // 17 RED events into a stalled FIFO: the last one is dropped.
    pulse_clear();
    for (int i = 0; i < 17; i++) begin
      drive_ev(8'(i), 8'h00, 1'b0, 8'(i + 1), 1'b0);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("full_level", level, 16);
    chk("full_drop", drop_cnt, 1);
    chk("full_overflow", overflow, 1);
    chk("full_cnt_red", cnt_red, 17);
    chk("full_head_a", bus.out_a, 0);

    pulse_clear();
    chk("clr_cnt_red", cnt_red, 0);
    chk("clr_drop", drop_cnt, 0);
    chk("clr_overflow", overflow, 0);
    chk("clr_level", level, 16);
    chk("clr_out_valid", bus.out_valid, 1);

    // Push and pop meet at stage 2 while full.
    drive_ev(8'h55, 8'h00, 1'b0, 8'h00, 1'b0);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("pp_level", level, 16);
    chk("pp_drop", drop_cnt, 0);
    chk("pp_overflow", overflow, 0);
    chk("pp_cnt_red", cnt_red, 1);
    chk("pp_head_a", bus.out_a, 1);

    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d_valid", i), bus.out_valid, 1);
      chk($sformatf("drain%0d_a", i), bus.out_a, (i < 15) ? (i + 1) : 32'h55);
      tick();
    end
    chk("drain_level", level, 0);
    chk("drain_out_valid", bus.out_valid, 0);
    tick();
    bus.out_ready = 1'b0;
    chk("empty_ready_level", level, 0);

    // Mid-run reset with five queued events and one in flight.
    pulse_clear();
    for (int i = 0; i < 5; i++) begin
      drive_ev(8'(8'h20 + i), 8'h00, 1'b0, 8'h00, 1'b0);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_level", level, 5);
    chk("pre_rst_cnt_red", cnt_red, 5);
    drive_ev(8'h77, 8'h00, 1'b0, 8'h00, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", bus.out_valid, 0);
    chk("mrst_level", level, 0);
    chk("mrst_cnt_red", cnt_red, 0);
    chk("mrst_out_a", bus.out_a, 0);
    chk("mrst_drop", drop_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("post_rst_level", level, 0);
    chk("post_rst_cnt_red", cnt_red, 0);
    chk("post_rst_out_valid", bus.out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
